stereolbm_axis_cambm_sdiv_52s_32s_33_seq: RTL and testbench

- Sequential signed restoring divider: the inverse operation to the pipelined 33s x 32s -> 52 multiplier in the disparity datapath.
- Recovers a 33-bit quotient and 32-bit remainder from a 52-bit product-domain value, e.g. normalising SAD-weighted sums for sub-pixel disparity.
- Uses one radix-2 step per clock enable, with a start/done handshake.
- Sits between the cost-aggregation accumulator and the disparity output stage.

---
 rtl/stereolbm_axis_cambm_sdiv_pkg.sv | 21 ++
 rtl/stereolbm_axis_cambm_sdiv_step.sv | 22 ++
 rtl/stereolbm_axis_cambm_sdiv_52s_32s_33_seq.sv | 149 ++++++++++++++
 tb/tb_stereolbm_axis_cambm_sdiv_52s_32s_33_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereolbm_axis_cambm_sdiv_pkg.sv
// rtl/stereolbm_axis_cambm_sdiv_pkg.sv - shared types and constants for the sequential signed divider
package stereolbm_axis_cambm_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIN0_WIDTH = 52;
    localparam int DIN1_WIDTH = 32;
    localparam int QUOT_WIDTH = 33;

    // Step counter must hold 0..DIN0_WIDTH
    localparam int CNT_WIDTH = $clog2(DIN0_WIDTH + 1);

    // Saturation limits of the signed quotient output
    localparam logic [QUOT_WIDTH-1:0] QMAX = {1'b0, {(QUOT_WIDTH-1){1'b1}}};
    localparam logic [QUOT_WIDTH-1:0] QMIN = {1'b1, {(QUOT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/stereolbm_axis_cambm_sdiv_step.sv
// rtl/stereolbm_axis_cambm_sdiv_step.sv - one combinational radix-2 restoring division step
module stereolbm_axis_cambm_sdiv_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] pr,
    input  logic         din_bit,
    input  logic [W-1:0] dmag,
    output logic [W-1:0] pr_next,
    output logic         qbit
);

    logic [W:0] shifted;

    // Shift in the next dividend bit and trial-subtract the divisor magnitude.
    // The partial remainder stays below dmag, so the difference always fits W bits.
    always_comb begin
        shifted = {pr, din_bit};
        qbit    = (shifted >= {1'b0, dmag});
        pr_next = qbit ? (shifted[W-1:0] - dmag) : shifted[W-1:0];
    end

endmodule

// File: rtl/stereolbm_axis_cambm_sdiv_52s_32s_33_seq.sv
// rtl/stereolbm_axis_cambm_sdiv_52s_32s_33_seq.sv - sequential signed divider with start/done handshake
module stereolbm_axis_cambm_sdiv_52s_32s_33_seq
    import stereolbm_axis_cambm_sdiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_WIDTH,
    parameter int din1_WIDTH = DIN1_WIDTH,
    parameter int quot_WIDTH = QUOT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [quot_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int N  = din0_WIDTH;
    localparam int XW = din0_WIDTH + 1;

    // Saturation limits widened to the signed magnitude-path width for comparison
    localparam logic [XW-1:0] qmax_ext = {{(XW-quot_WIDTH){1'b0}}, QMAX};
    localparam logic [XW-1:0] qmin_ext = {{(XW-quot_WIDTH){1'b1}}, QMIN};

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [N-1:0]           dq;        // dividend magnitude shifting out, quotient bits shifting in
    logic [din1_WIDTH-1:0]  pr;
    logic [din1_WIDTH-1:0]  dmag;
    logic [din1_WIDTH-1:0]  pr_step;
    logic                   qbit;
    logic                   s0;
    logic                   s1;
    logic                   dz;
    logic [XW-1:0]          q_signed;
    logic [din1_WIDTH-1:0]  r_signed;
    logic                   q_hi;
    logic                   q_lo;

    stereolbm_axis_cambm_sdiv_step #(
        .W (din1_WIDTH)
    ) u_step (
        .pr      (pr),
        .din_bit (dq[N-1]),
        .dmag    (dmag),
        .pr_next (pr_step),
        .qbit    (qbit)
    );

    // State register; ce=0 freezes the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next-state logic: N restoring steps then a single sign/saturation pass
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CNT_WIDTH'(N - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: a new request is accepted only in IDLE
    always_comb begin
        ready = (state == IDLE);
    end

    // Re-apply signs to the magnitudes and detect quotient range violations
    always_comb begin
        q_signed = (s0 ^ s1) ? (XW'(0) - {1'b0, dq}) : {1'b0, dq};
        r_signed = s0 ? (din1_WIDTH'(0) - pr) : pr;
        q_hi     = $signed(q_signed) > $signed(qmax_ext);
        q_lo     = $signed(q_signed) < $signed(qmin_ext);
    end

    // Datapath: capture operands, iterate, then register final results with a done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            dq          <= '0;
            pr          <= '0;
            dmag        <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s0   <= din0[N-1];
                        s1   <= din1[din1_WIDTH-1];
                        dz   <= (din1 == '0);
                        dq   <= din0[N-1] ? (N'(0) - din0) : din0;
                        dmag <= din1[din1_WIDTH-1] ? (din1_WIDTH'(0) - din1) : din1;
                        pr   <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    dq  <= {dq[N-2:0], qbit};
                    pr  <= pr_step;
                    cnt <= cnt + CNT_WIDTH'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        quot        <= s0 ? QMIN : QMAX;
                        rem         <= '0;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        rem         <= r_signed;
                        div_by_zero <= 1'b0;
                        overflow    <= q_hi | q_lo;
                        if (q_hi) begin
                            quot <= QMAX;
                        end else if (q_lo) begin
                            quot <= QMIN;
                        end else begin
                            quot <= q_signed[quot_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stereolbm_axis_cambm_sdiv_52s_32s_33_seq.sv
// tb/tb_stereolbm_axis_cambm_sdiv_52s_32s_33_seq.sv - directed self-checking bench for the sequential divider
module tb_stereolbm_axis_cambm_sdiv_52s_32s_33_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [51:0] din0;
    logic [31:0] din1;
    logic        ready;
    logic        done;
    logic [32:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    stereolbm_axis_cambm_sdiv_52s_32s_33_seq dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .ready       (ready),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_div(input logic [51:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        #12;
        checks++;
        if ({ready, done, div_by_zero, overflow} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {ready, done, div_by_zero, overflow}, 4'b1000);
        end
        checks++;
        if (quot !== 33'h0 || rem !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got quot=%h rem=%h exp 0 0", quot, rem);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        run_div(52'd1000, 32'd7, lat);
        checks++;
        if (lat !== 53) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=53", lat);
        end
        checks++;
        if (quot !== 33'd142 || rem !== 32'd6) begin
            failures++;
            $display("FAIL basic_result got q=%h r=%h exp q=%h r=%h", quot, rem, 33'd142, 32'd6);
        end
        checks++;
        if ({div_by_zero, overflow} !== 2'b00) begin
            failures++;
            $display("FAIL basic_flags got=%b exp=00", {div_by_zero, overflow});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quot !== 33'd142) begin
            failures++;
            $display("FAIL done_pulse_hold got done=%b q=%h exp done=0 q=%h", done, quot, 33'd142);
        end
    endtask

    task automatic test_signs;
        logic [51:0] a_t [4];
        logic [31:0] b_t [4];
        logic [32:0] q_t [4];
        logic [31:0] r_t [4];
        int lat;
        a_t = '{-52'sd1000, 52'sd1000, -52'sd1000, 52'sd0};
        b_t = '{32'sd7, -32'sd7, -32'sd7, 32'sd5};
        q_t = '{-33'sd142, -33'sd142, 33'sd142, 33'sd0};
        r_t = '{-32'sd6, 32'sd6, -32'sd6, 32'sd0};
        for (int i = 0; i < 4; i++) begin
            run_div(a_t[i], b_t[i], lat);
            checks++;
            if (quot !== q_t[i] || rem !== r_t[i]) begin
                failures++;
                $display("FAIL sign_case%0d got q=%h r=%h exp q=%h r=%h", i, quot, rem, q_t[i], r_t[i]);
            end
            checks++;
            if ({div_by_zero, overflow} !== 2'b00 || lat !== 53) begin
                failures++;
                $display("FAIL sign_case%0d_flags got f=%b lat=%0d exp f=00 lat=53", i, {div_by_zero, overflow}, lat);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        run_div(52'd123, 32'd0, lat);
        checks++;
        if (quot !== 33'h0_FFFF_FFFF || rem !== 32'h0) begin
            failures++;
            $display("FAIL dz_pos got q=%h r=%h exp q=%h r=0", quot, rem, 33'h0_FFFF_FFFF);
        end
        checks++;
        if ({div_by_zero, overflow} !== 2'b10 || lat !== 53) begin
            failures++;
            $display("FAIL dz_pos_flags got f=%b lat=%0d exp f=10 lat=53", {div_by_zero, overflow}, lat);
        end
        run_div(-52'sd5, 32'd0, lat);
        checks++;
        if (quot !== 33'h1_0000_0000 || rem !== 32'h0) begin
            failures++;
            $display("FAIL dz_neg got q=%h r=%h exp q=%h r=0", quot, rem, 33'h1_0000_0000);
        end
        checks++;
        if ({div_by_zero, overflow} !== 2'b10) begin
            failures++;
            $display("FAIL dz_neg_flags got=%b exp=10", {div_by_zero, overflow});
        end
    endtask

    task automatic test_overflow;
        int lat;
        run_div(52'h8_0000_0000_0000, 32'd1, lat);
        checks++;
        if (quot !== 33'h1_0000_0000 || rem !== 32'h0 || {div_by_zero, overflow} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_minneg got q=%h r=%h f=%b exp q=%h r=0 f=01", quot, rem, {div_by_zero, overflow}, 33'h1_0000_0000);
        end
        run_div(52'h7_FFFF_FFFF_FFFF, -32'sd1, lat);
        checks++;
        if (quot !== 33'h1_0000_0000 || rem !== 32'h0 || {div_by_zero, overflow} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_negone got q=%h r=%h f=%b exp q=%h r=0 f=01", quot, rem, {div_by_zero, overflow}, 33'h1_0000_0000);
        end
        run_div(52'h100_0000_0000, 32'd256, lat);
        checks++;
        if (quot !== 33'h0_FFFF_FFFF || rem !== 32'h0 || {div_by_zero, overflow} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_pos got q=%h r=%h f=%b exp q=%h r=0 f=01", quot, rem, {div_by_zero, overflow}, 33'h0_FFFF_FFFF);
        end
    endtask

    task automatic test_ce_stall;
        int lat;
        logic seen;
        @(negedge clk);
        din0  = 52'd1000;
        din1  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready got=%b exp=0", ready);
        end
        din0  = 52'd5;
        din1  = 32'd1;
        start = 1'b1;
        @(negedge clk);
        lat++;
        ce = 1'b0;
        repeat (10) begin
            @(negedge clk);
            lat++;
        end
        ce    = 1'b1;
        start = 1'b0;
        while (done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 63) begin
            failures++;
            $display("FAIL stall_latency got=%0d exp=63", lat);
        end
        checks++;
        if (quot !== 33'd142 || rem !== 32'd6) begin
            failures++;
            $display("FAIL stall_result got q=%h r=%h exp q=%h r=%h", quot, rem, 33'd142, 32'd6);
        end
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen = seen | done | ~ready;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL stall_start_not_queued got busy_or_done=%b exp=0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_div(52'd1000, 32'd7, lat);
        checks++;
        if (ready !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_ready got ready=%b done=%b exp 1 1", ready, done);
        end
        din0  = -52'sd1000;
        din1  = -32'sd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 53) begin
            failures++;
            $display("FAIL b2b_latency got=%0d exp=53", lat);
        end
        checks++;
        if (quot !== 33'd142 || rem !== -32'sd6) begin
            failures++;
            $display("FAIL b2b_result got q=%h r=%h exp q=%h r=%h", quot, rem, 33'd142, -32'sd6);
        end
    endtask

    task automatic test_async_reset;
        int lat;
        logic seen;
        @(negedge clk);
        din0  = 52'd1000;
        din1  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ready, done, div_by_zero, overflow} !== 4'b1000) begin
            failures++;
            $display("FAIL async_reset_flags got=%b exp=1000", {ready, done, div_by_zero, overflow});
        end
        checks++;
        if (quot !== 33'h0 || rem !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_data got q=%h r=%h exp 0 0", quot, rem);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            seen = seen | done;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_no_done got=%b exp=0", seen);
        end
        run_div(52'd1000, 32'd7, lat);
        checks++;
        if (quot !== 33'd142 || rem !== 32'd6 || lat !== 53) begin
            failures++;
            $display("FAIL post_reset_div got q=%h r=%h lat=%0d exp q=%h r=%h lat=53", quot, rem, lat, 33'd142, 32'd6);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_ce_stall();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
